// File: rtl/uarch_pkg.sv
// rtl/uarch_pkg.sv - shared ROB sizing constants, pointer type and wrap-aware add
package uarch_pkg;

  localparam int ROB_ENTRIES = 32;
  localparam int TAG_WIDTH   = $clog2(ROB_ENTRIES);

  // One extra wrap bit above the tag distinguishes full from empty when
  // head and tail tags coincide.
  typedef logic [TAG_WIDTH:0] rob_ptr_t;

  // Advance a pointer by 0..3; the natural overflow of the wrap bit gives
  // modulo 2*ROB_ENTRIES arithmetic.
  function automatic rob_ptr_t rob_ptr_add(rob_ptr_t ptr, logic [1:0] inc);
    return ptr + rob_ptr_t'(inc);
  endfunction

endpackage

// File: rtl/rob_alloc_ctrl.sv
// rtl/rob_alloc_ctrl.sv - in-order dual-slot ROB entry allocator with head/tail tracking
module rob_alloc_ctrl
  import uarch_pkg::*;
#(
  parameter int ROB_ENTRIES = uarch_pkg::ROB_ENTRIES,
  parameter int TAG_WIDTH   = $clog2(ROB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           alloc_req,
  output logic [1:0]           alloc_gnt,
  output logic [TAG_WIDTH-1:0] rob_tag0,
  output logic [TAG_WIDTH-1:0] rob_tag1,
  input  logic                 alloc_fire,
  input  logic [1:0]           commit_cnt,
  output logic [TAG_WIDTH-1:0] head_tag,
  output logic [TAG_WIDTH:0]   occupancy,
  output logic                 rob_empty,
  output logic                 rob_full,
  output logic                 ovf_err
);

  localparam int PW = TAG_WIDTH + 1;
  localparam logic [PW-1:0] OCC_FULL   = PW'(ROB_ENTRIES);
  localparam logic [PW-1:0] OCC_ALMOST = PW'(ROB_ENTRIES - 1);

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] occ_q;

  logic          free_ge1;
  logic          free_ge2;
  logic [1:0]    n_alloc;
  logic [1:0]    n_ret;
  logic          commit_ovf;
  logic [PW-1:0] head_nxt;
  logic [PW-1:0] tail_nxt;
  logic [PW-1:0] occ_nxt;

  // Free-space tests against registered occupancy only; same-cycle commits
  // never make room for a same-cycle grant.
  assign free_ge1 = (occ_q < OCC_FULL);
  assign free_ge2 = (occ_q < OCC_ALMOST);

  // In-order grants: slot 1 can only win when slot 0 is idle or also won.
  always_comb begin
    alloc_gnt = 2'b00;
    if (!rst && !flush) begin
      alloc_gnt[0] = alloc_req[0] && free_ge1;
      if (alloc_req[0]) begin
        alloc_gnt[1] = alloc_req[1] && alloc_gnt[0] && free_ge2;
      end else begin
        alloc_gnt[1] = alloc_req[1] && free_ge1;
      end
    end
  end

  // Tags are offered every cycle regardless of grant; slot 1 skips past slot 0
  // only when slot 0 is asking for an entry.
  assign rob_tag0 = tail_ptr[TAG_WIDTH-1:0];
  assign rob_tag1 = tail_ptr[TAG_WIDTH-1:0] + TAG_WIDTH'(alloc_req[0]);

  // Retire and allocate amounts; commits beyond the live count are clamped
  // and flagged as a protocol error.
  always_comb begin
    n_alloc    = 2'd0;
    n_ret      = commit_cnt;
    commit_ovf = 1'b0;
    if (alloc_fire) begin
      n_alloc = {1'b0, alloc_gnt[0]} + {1'b0, alloc_gnt[1]};
    end
    if (PW'(commit_cnt) > occ_q) begin
      n_ret      = occ_q[1:0];
      commit_ovf = 1'b1;
    end
  end

  // Next pointer/count values; flush discards every uncommitted entry by
  // collapsing tail onto the post-commit head.
  always_comb begin
    head_nxt = head_ptr + PW'(n_ret);
    tail_nxt = tail_ptr + PW'(n_alloc);
    occ_nxt  = occ_q + PW'(n_alloc) - PW'(n_ret);
    if (flush) begin
      tail_nxt = head_nxt;
      occ_nxt  = '0;
    end
  end

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      occ_q    <= '0;
      ovf_err  <= 1'b0;
    end else begin
      head_ptr <= head_nxt;
      tail_ptr <= tail_nxt;
      occ_q    <= occ_nxt;
      if (commit_ovf) begin
        ovf_err <= 1'b1;
      end
    end
  end

  assign head_tag  = head_ptr[TAG_WIDTH-1:0];
  assign occupancy = occ_q;
  assign rob_empty = (occ_q == '0);
  assign rob_full  = (occ_q == OCC_FULL);

endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
Allocation controller for the ROB tag space. Each cycle it grants 0, 1 or 2 in-order ROB entries to the rename stage and supplies their tags combinationally. It advances the tail pointer when rename actually advances, and frees entries from the head on commit. It sits between rename (which consumes the grants and tags) and the ROB/commit logic (which retires entries and drives flush).

Parameters:
ROB_ENTRIES, 32, number of ROB entries; must be a power of two, at least 4.
TAG_WIDTH, $clog2(ROB_ENTRIES), ROB tag width; matches the TAG_WIDTH in uarch_pkg.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
flush  in  1  squash all uncommitted entries.
alloc_req  in  2  per-slot request from rename; bit0 = inst0, bit1 = inst1.
alloc_gnt  out  2  per-slot grant, combinational.
rob_tag0  out  TAG_WIDTH  tag for slot 0.
rob_tag1  out  TAG_WIDTH  tag for slot 1.
alloc_fire  in  1  rename advanced this cycle (rename_rdy); consumes the current grants.
commit_cnt  in  2  number of entries retired at the head this cycle (0..2).
head_tag  out  TAG_WIDTH  tag of the oldest live entry.
occupancy  out  TAG_WIDTH+1  number of live entries.
rob_empty  out  1  occupancy == 0.
rob_full  out  1  occupancy == ROB_ENTRIES.
ovf_err  out  1  sticky error flag.

Behaviour:
- State: head and tail pointers, each TAG_WIDTH+1 bits with a wrap bit; an occupancy counter; the ovf_err flag. Tags are pointer[TAG_WIDTH-1:0]. Pointers wrap modulo 2*ROB_ENTRIES.
- free = ROB_ENTRIES - occupancy.
- Grants are in order and combinational (zero-cycle):
  - gnt[0] = req[0] && free >= 1.
  - gnt[1] = req[1] && (req[0] ? (gnt[0] && free >= 2) : free >= 1).
  - Slot 1 is never granted while slot 0 is requested but denied.
- Tags:
  - rob_tag0 = tail.
  - rob_tag1 = tail + req[0], modulo ROB_ENTRIES.
  - Tags are driven whether or not the grant is set.
- Alloc amount:
  - n_alloc = alloc_fire ? popcount(alloc_gnt) : 0.
  - Grants that are not fired do not move tail; the same tags are re-offered next cycle.
- Retire amount:
  - n_ret = min(commit_cnt, occupancy).
  - If commit_cnt > occupancy, ovf_err sets and stays set until reset.
- Update on posedge clk (normal case):
  - head += n_ret.
  - tail += n_alloc.
  - occupancy += n_alloc - n_ret.
  - Allocation and commit in the same cycle, including at full, are both applied. Same-cycle frees do not raise free; grants use registered occupancy only.
- Flush (priority over allocation):
  - head += n_ret.
  - tail = new head.
  - occupancy = 0.
  - alloc_fire is ignored that cycle, and alloc_gnt is forced to 0 while flush is high.
- Full / empty:
  - At occupancy == ROB_ENTRIES, both grants are 0.
  - At occupancy == ROB_ENTRIES-1, only one grant is issued, to the oldest requesting slot.
  - At empty, commit_cnt != 0 sets ovf_err and leaves the state unchanged.
- Reset (asynchronous, any time, including mid-allocation):
  - head = tail = 0, occupancy = 0, ovf_err = 0.
  - rob_empty = 1, rob_full = 0, head_tag = 0.
  - alloc_gnt is forced to 0 while rst is high.
  - rob_tag0 = 0; rob_tag1 = req[0].
- Latency: grants and tags are available in the same cycle; pointer, occupancy and status outputs are visible the next cycle.

Decomposition:
- uarch_pkg: ROB_ENTRIES and TAG_WIDTH constants, a rob_ptr_t typedef (TAG_WIDTH+1 bits), and a rob_ptr_add function for wrap-aware addition.
- No sub-module: the pointer, counter and grant logic is one block, roughly 150 lines of RTL.
- SVA in the bench:
  - occupancy <= ROB_ENTRIES.
  - tail - head == occupancy.
  - gnt[1] implies gnt[0] whenever req[0] is set.

Test Plan:
- Reset, then req=2'b11 with fire for 3 cycles -> gnt=11; tags (0,1), (2,3), (4,5); occupancy=6.
- Fill to 31 entries with ROB_ENTRIES=32, req=11 -> gnt=01, tag0=31; after fire, rob_full=1 and a later req=11 gives gnt=00.
- Full, commit_cnt=2 together with req=11 and fire -> gnt=00 that cycle; next cycle occupancy=30 and gnt=11 with tags 0,1 (wrap).
- req=2'b10 at tail=5 -> gnt=10, rob_tag1=5; after fire, tail=6.
- req=11 with fire=0 for 2 cycles -> tags unchanged at (tail, tail+1); occupancy unchanged.
- occupancy=10, head=3, flush with commit_cnt=1 -> next cycle head=4, tail=4, occupancy=0, rob_empty=1.
- Separately, commit_cnt=2 with occupancy=1 -> ovf_err=1, and it holds until rst pulses asynchronously mid-cycle, which clears all state immediately.
